// File: rtl/k423_id_ibuf.sv
// Decode-stage instruction buffer: circular FIFO of (pc, inst) pairs between IF and decode/EX,
// with optional zero-latency bypass when empty, plus flush and hazard-stall controls.
module k423_id_ibuf #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int INST_W = 32,
    parameter int BYPASS = 1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       id_stall_i,
    input  logic                       if_stage_vld_i,
    output logic                       id_stage_rdy_o,
    input  logic [ADDR_W-1:0]          if_pc_i,
    input  logic [INST_W-1:0]          if_inst_i,
    output logic                       id_stage_vld_o,
    input  logic                       ex_stage_rdy_i,
    output logic [ADDR_W-1:0]          id_pc_o,
    output logic [INST_W-1:0]          id_inst_o,
    output logic [$clog2(DEPTH+1)-1:0] id_buf_cnt_o,
    output logic                       id_buf_full_o,
    output logic                       id_buf_empty_o
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH+1);
    localparam int ENT_W  = ADDR_W + INST_W;
    localparam bit BYP_EN = (BYPASS != 0);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [ENT_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wp_q, wp_d;
    logic [PTR_W-1:0] rp_q, rp_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic full, empty, kill;
    logic byp_sel, head_vld;
    logic in_fire, out_fire, thru;
    logic push, pop;
    logic [ENT_W-1:0] head_ent;

    assign full  = (cnt_q == FULL_CNT);
    assign empty = (cnt_q == '0);
    assign kill  = flush_i | rst_i;

    // Ready deliberately ignores ex_stage_rdy_i: no combinational ready path through the buffer.
    assign id_stage_rdy_o = ~full & ~kill;

    assign byp_sel  = BYP_EN & empty;
    assign head_vld = byp_sel ? if_stage_vld_i : ~empty;
    assign id_stage_vld_o = head_vld & ~id_stall_i & ~kill;

    assign head_ent  = byp_sel ? {if_pc_i, if_inst_i} : mem_q[rp_q];
    assign id_pc_o   = id_stage_vld_o ? head_ent[ENT_W-1:INST_W] : '0;
    assign id_inst_o = id_stage_vld_o ? head_ent[INST_W-1:0]     : '0;

    assign in_fire  = if_stage_vld_i & id_stage_rdy_o;
    assign out_fire = id_stage_vld_o & ex_stage_rdy_i;

    // A bypassed instruction goes straight through and never touches storage.
    assign thru = byp_sel & in_fire & out_fire;
    assign push = in_fire & ~thru;
    assign pop  = out_fire & ~thru;

    always_comb begin
        wp_d  = wp_q;
        rp_d  = rp_q;
        cnt_d = cnt_q;
        if (push) wp_d = wp_q + PTR_W'(1);
        if (pop)  rp_d = rp_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (kill) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wp_q] <= {if_pc_i, if_inst_i};
    end

    assign id_buf_cnt_o   = cnt_q;
    assign id_buf_full_o  = full;
    assign id_buf_empty_o = empty;

endmodule
